serial_word_queue: RTL and testbench
====================================

# serial_word_queue

Parametrised serial-to-parallel front end with an integrated word FIFO. It is the next generation of the deserializer plus queue pair, with these additions:
- configurable word width, queue depth and bit order;
- selectable full-queue policy (stall or drop);
- framing-error detection;
- edge-detected dequeue.

Everything runs in a single clock domain, so no cross-domain handshake synchronisers are needed.

## Interface
- WORD_WIDTH, 8: bits per word; must be ≥ 2.
- DEPTH, 8: FIFO entries; must be ≥ 2; need not be a power of two.
- LSB_FIRST, 1: 1 means the first serial bit is bit 0; 0 means the first serial bit is bit WORD_WIDTH-1.
- FULL_POLICY, 0: 0 stalls the deserializer while the queue is full; 1 drops the word and pulses overflow_out.
- LEN_W, $clog2(DEPTH+1): width of len_out (derived).
- clock_1MHz  input  1  single clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low; the block is held in reset while it is 0.
- data_in  input  1  serial data bit.
- write_in  input  1  frame enable; one bit is sampled per clock while it is high.
- dequeue_in  input  1  level input; exactly one pop per rising edge.
- status_out  output  1  1 means the deserializer can accept a new frame.
- data_out  output  WORD_WIDTH  head-of-queue word; 0 when the queue is empty.
- len_out  output  LEN_W  number of stored words.
- full_out / empty_out  output  1  len_out == DEPTH / len_out == 0.
- overflow_out  output  1  one-cycle pulse when a word is dropped (FULL_POLICY=1).
- frame_error_out  output  1  one-cycle pulse when write_in falls mid-word.

## Operation
Deserializer FSM states: IDLE, SHIFT, PUSH, STALL.

IDLE
- status_out=1.
- If write_in=1: sample data_in as bit 1, count=1, go to SHIFT.

SHIFT
- If write_in=1: sample data_in and increment count.
- When count reaches WORD_WIDTH, the word is complete; go to PUSH.
- If write_in=0 before the word is complete: pulse frame_error_out, discard the partial word, go to IDLE.

PUSH
- status_out=0; write_in and data_in are ignored.
- If there is space (len_out<DEPTH, or a pop fires in the same cycle): enqueue, go to IDLE.
- Else with FULL_POLICY=0: go to STALL.
- Else with FULL_POLICY=1: pulse overflow_out, discard the word, go to IDLE.

STALL
- status_out=0.
- Enqueue on the first cycle with space (including a same-cycle pop), then go to IDLE.

FIFO
- head and tail pointers wrap from DEPTH-1 to 0 (modulo DEPTH, no power-of-two assumption); a separate count drives len_out.
- Pop fires when dequeue_in=1 and its registered previous value=0, and len_out>0.
- A pop on an empty queue is ignored silently, and that edge is consumed.
- Simultaneous push and pop:
  - when full: both execute and len_out is unchanged;
  - when empty: the pop is ignored and the push executes, so len_out becomes 1.
- data_out is combinational from mem[head], gated to 0 when the queue is empty.

Reset (asynchronous, at any time)
- FSM goes to IDLE; count, pointers, len and the dequeue edge register all clear.
- Any partial or pending word is lost.
- Output values during reset: status_out=1, data_out=0, len_out=0, empty_out=1, full_out=0, overflow_out=0, frame_error_out=0.

## Timing
- Bit k of a frame is sampled on the k-th rising edge with write_in=1.
- The edge that samples the last bit moves the FSM to PUSH. The enqueue happens on the next edge, so len_out and data_out update 2 edges after the last bit is sampled.
- write_in may stay high across frames. The bit present during the PUSH cycle is ignored, and a new frame begins on the following IDLE cycle.
- A pop updates len_out and data_out on the same edge that sees the dequeue rising edge, i.e. 1 cycle after dequeue_in rises.
- overflow_out and frame_error_out are registered and are each high for exactly 1 cycle.

## Structure
- Package serial_queue_pkg holds:
  - typedef enum deser_state_t {IDLE, SHIFT, PUSH, STALL};
  - constants FULL_STALL=0, FULL_DROP=1.
- Sub-module word_fifo (parameters WORD_WIDTH and DEPTH): storage, wrapping pointers, count, full/empty, and the push/pop arbitration rules above.
- The top level contains the FSM, the shift register and bit counter, and the dequeue edge detector.

## Test plan
1. Defaults. Send 0xA3 LSB-first as bits 1,1,0,0,0,1,0,1 with write_in high for 8 cycles → 2 edges after the last bit, len_out=1 and data_out=0xA3.
2. Then send 0x5C (0,0,1,1,1,0,1,0) → len_out=2, data_out=0xA3. Hold dequeue_in high for 100 cycles → exactly one pop: len_out=1, data_out=0x5C. A second pulse gives len_out=0 and data_out=0; a third pulse on the empty queue is a no-op.
3. FULL_POLICY=0. Enqueue 8 words, then send a 9th → status_out stays 0 and len_out=8. Pulse dequeue → the 9th word is enqueued on the same edge as the pop, len_out stays 8, and FIFO order is preserved.
4. FULL_POLICY=1. Same fill, then a 9th word → overflow_out is high for 1 cycle, len_out=8, contents unchanged.
5. Drop write_in after 3 bits → frame_error_out pulses for 1 cycle and len_out is unchanged. The next full frame 0x3C is stored correctly.
6. LSB_FIRST=0, DEPTH=5. Stream 12 words while popping so the pointers wrap → the output order matches the input order. Then assert reset mid-frame with len_out=3 → all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/serial_queue_pkg.sv
// Shared types and constants for the serial word queue: deserializer states
// and the full-queue policy encodings.
package serial_queue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PUSH,
        STALL
    } deser_state_t;

    localparam int FULL_STALL = 0;
    localparam int FULL_DROP  = 1;

endpackage

// File: rtl/word_fifo.sv
// Word FIFO with modulo-DEPTH pointers and a separate occupancy count.
// A push into a full queue is accepted only when a pop fires on the same edge.
module word_fifo
    import serial_queue_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int LEN_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clock_1MHz,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  push_accept,
    output logic                  pop_accept,
    output logic [WORD_WIDTH-1:0] data,
    output logic [LEN_W-1:0]      len,
    output logic                  full,
    output logic                  empty
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [LEN_W-1:0]      count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == LEN_W'(DEPTH));
    assign pop_accept  = pop && !empty;
    assign push_accept = push && (!full || pop_accept);
    assign len         = count;
    assign data        = empty ? '0 : mem[head];

    always_ff @(posedge clock_1MHz or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_accept) tail <= ptr_inc(tail);
            if (pop_accept)  head <= ptr_inc(head);
            case ({push_accept, pop_accept})
                2'b10:   count <= count + LEN_W'(1);
                2'b01:   count <= count - LEN_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge clock_1MHz) begin
        if (push_accept) mem[tail] <= push_data;
    end

endmodule

// File: rtl/serial_word_queue.sv
// Serial-to-parallel front end feeding a word FIFO, with stall/drop full
// policy, framing-error detection and an edge-detected dequeue.
//
// state | meaning
// IDLE  | ready for a frame; a high write_in samples the first bit
// SHIFT | collecting the remaining bits of the current word
// PUSH  | word complete; enqueue, stall or drop depending on space/policy
// STALL | queue full; hold the word until a slot frees up
module serial_word_queue
    import serial_queue_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int FULL_POLICY = FULL_STALL,
    localparam int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock_1MHz,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  dequeue_in,
    output logic                  status_out,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic [LEN_W-1:0]      len_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic                  frame_error_out
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    deser_state_t          state;
    deser_state_t          state_next;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bits_left;
    logic                  shift_en;
    logic                  cnt_load;
    logic                  push_req;
    logic                  push_accept;
    logic                  pop_accept;
    logic                  deq_prev;
    logic                  pop_req;
    logic                  ovf_next;
    logic                  ferr_next;

    // Every rising edge is consumed, even one that finds the queue empty.
    assign pop_req = dequeue_in && !deq_prev;

    word_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock_1MHz  (clock_1MHz),
        .reset       (reset),
        .push        (push_req),
        .push_data   (shift_reg),
        .pop         (pop_req),
        .push_accept (push_accept),
        .pop_accept  (pop_accept),
        .data        (data_out),
        .len         (len_out),
        .full        (full_out),
        .empty       (empty_out)
    );

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cnt_load   = 1'b0;
        push_req   = 1'b0;
        status_out = 1'b0;
        ovf_next   = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                status_out = 1'b1;
                if (write_in) begin
                    shift_en   = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (write_in) begin
                    shift_en = 1'b1;
                    if (bits_left == CNT_W'(1)) state_next = PUSH;
                end else begin
                    ferr_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            PUSH: begin
                push_req = 1'b1;
                if (push_accept) begin
                    state_next = IDLE;
                end else if (FULL_POLICY == FULL_DROP) begin
                    ovf_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = STALL;
                end
            end
            STALL: begin
                push_req = 1'b1;
                if (push_accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_1MHz or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bits_left       <= '0;
            deq_prev        <= 1'b0;
            overflow_out    <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            state           <= state_next;
            deq_prev        <= dequeue_in;
            overflow_out    <= ovf_next;
            frame_error_out <= ferr_next;
            if (cnt_load)      bits_left <= CNT_W'(WORD_WIDTH - 1);
            else if (shift_en) bits_left <= bits_left - CNT_W'(1);
        end
    end

    // A partial word is simply overwritten by the next full frame.
    always_ff @(posedge clock_1MHz or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST) shift_reg <= {data_in, shift_reg[WORD_WIDTH-1:1]};
            else           shift_reg <= {shift_reg[WORD_WIDTH-2:0], data_in};
        end
    end

endmodule

// File: tb/tb_serial_word_queue.sv
// Bench for serial_word_queue: three configurations checked every cycle
// against a queue-based model, plus hand-computed expectations.
module tb_serial_word_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       din [3];
    logic       wr  [3];
    logic       deq [3];
    logic       st  [3];
    logic [7:0] dq  [3];
    logic       fl  [3];
    logic       em  [3];
    logic       ovf [3];
    logic       fe  [3];
    logic [3:0] len0;
    logic [3:0] len1;
    logic [2:0] len2;

    int n_cmp = 0;
    int n_bad = 0;

    // Configurations: u0 defaults, u1 drop policy, u2 MSB-first depth 5.
    int m_depth [3] = '{8, 8, 5};
    bit m_lsb   [3] = '{1'b1, 1'b1, 1'b0};
    bit m_drop  [3] = '{1'b0, 1'b1, 1'b0};

    serial_word_queue #(.WORD_WIDTH(8), .DEPTH(8), .LSB_FIRST(1'b1), .FULL_POLICY(0)) u0 (
        .clock_1MHz(clk), .reset(rst_n), .data_in(din[0]), .write_in(wr[0]),
        .dequeue_in(deq[0]), .status_out(st[0]), .data_out(dq[0]), .len_out(len0),
        .full_out(fl[0]), .empty_out(em[0]), .overflow_out(ovf[0]), .frame_error_out(fe[0]));

    serial_word_queue #(.WORD_WIDTH(8), .DEPTH(8), .LSB_FIRST(1'b1), .FULL_POLICY(1)) u1 (
        .clock_1MHz(clk), .reset(rst_n), .data_in(din[1]), .write_in(wr[1]),
        .dequeue_in(deq[1]), .status_out(st[1]), .data_out(dq[1]), .len_out(len1),
        .full_out(fl[1]), .empty_out(em[1]), .overflow_out(ovf[1]), .frame_error_out(fe[1]));

    serial_word_queue #(.WORD_WIDTH(8), .DEPTH(5), .LSB_FIRST(1'b0), .FULL_POLICY(0)) u2 (
        .clock_1MHz(clk), .reset(rst_n), .data_in(din[2]), .write_in(wr[2]),
        .dequeue_in(deq[2]), .status_out(st[2]), .data_out(dq[2]), .len_out(len2),
        .full_out(fl[2]), .empty_out(em[2]), .overflow_out(ovf[2]), .frame_error_out(fe[2]));

    function automatic int dut_len(input int i);
        if (i == 0) return int'(len0);
        if (i == 1) return int'(len1);
        return int'(len2);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word queue per instance, a bit collector and a pending word
    // that waits for a free slot (or is dropped under the drop policy).
    logic [7:0] mq [3][$];
    int         nb   [3] = '{0, 0, 0};
    logic [7:0] acc  [3] = '{8'h0, 8'h0, 8'h0};
    bit         pend [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] pw   [3] = '{8'h0, 8'h0, 8'h0};
    bit         mprev[3] = '{1'b0, 1'b0, 1'b0};
    bit         e_ovf[3] = '{1'b0, 1'b0, 1'b0};
    bit         e_fe [3] = '{1'b0, 1'b0, 1'b0};

    task automatic model_step();
        bit pop;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                nb[i] = 0; acc[i] = 8'h0; pend[i] = 1'b0;
                mprev[i] = 1'b0; e_ovf[i] = 1'b0; e_fe[i] = 1'b0;
            end else begin
                pop = deq[i] && !mprev[i] && (mq[i].size() > 0);
                mprev[i] = deq[i];
                e_ovf[i] = 1'b0;
                e_fe[i]  = 1'b0;
                if (pop) void'(mq[i].pop_front());
                if (pend[i]) begin
                    if (mq[i].size() < m_depth[i]) begin
                        mq[i].push_back(pw[i]);
                        pend[i] = 1'b0;
                    end else if (m_drop[i]) begin
                        e_ovf[i] = 1'b1;
                        pend[i]  = 1'b0;
                    end
                end else if (wr[i]) begin
                    acc[i][3'(m_lsb[i] ? nb[i] : 7 - nb[i])] = din[i];
                    nb[i]++;
                    if (nb[i] == 8) begin
                        pend[i] = 1'b1;
                        pw[i]   = acc[i];
                        nb[i]   = 0;
                        acc[i]  = 8'h0;
                    end
                end else if (nb[i] > 0) begin
                    e_fe[i] = 1'b1;
                    nb[i]   = 0;
                    acc[i]  = 8'h0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d status", i), int'(st[i]), int'(nb[i] == 0 && !pend[i]));
                check($sformatf("u%0d data", i), int'(dq[i]),
                      (mq[i].size() > 0) ? int'(mq[i][0]) : 0);
                check($sformatf("u%0d len", i), dut_len(i), mq[i].size());
                check($sformatf("u%0d full", i), int'(fl[i]), int'(mq[i].size() == m_depth[i]));
                check($sformatf("u%0d empty", i), int'(em[i]), int'(mq[i].size() == 0));
                check($sformatf("u%0d overflow", i), int'(ovf[i]), int'(e_ovf[i]));
                check($sformatf("u%0d frame_error", i), int'(fe[i]), int'(e_fe[i]));
            end
        end
    end

    // Returns on the negedge after the enqueue edge of this word.
    task automatic send_word(input int i, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wr[i]  = 1'b1;
            din[i] = m_lsb[i] ? w[k] : w[7-k];
        end
        @(negedge clk);
        wr[i]  = 1'b0;
        din[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_deq(input int i, input int hold);
        @(negedge clk);
        deq[i] = 1'b1;
        repeat (hold) @(negedge clk);
        deq[i] = 1'b0;
    endtask

    task automatic check_reset_vals(input int i);
        check($sformatf("u%0d reset status", i), int'(st[i]), 1);
        check($sformatf("u%0d reset data", i), int'(dq[i]), 0);
        check($sformatf("u%0d reset len", i), dut_len(i), 0);
        check($sformatf("u%0d reset empty", i), int'(em[i]), 1);
        check($sformatf("u%0d reset full", i), int'(fl[i]), 0);
        check($sformatf("u%0d reset overflow", i), int'(ovf[i]), 0);
        check($sformatf("u%0d reset frame_error", i), int'(fe[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = 1'b0; wr[i] = 1'b0; deq[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1-2: basic frames and level-held dequeue
        send_word(0, 8'hA3);
        check("t1 len", dut_len(0), 1);
        check("t1 data", int'(dq[0]), 'hA3);
        send_word(0, 8'h5C);
        check("t2 len", dut_len(0), 2);
        check("t2 head", int'(dq[0]), 'hA3);
        pulse_deq(0, 100);
        check("t2 pop1 len", dut_len(0), 1);
        check("t2 pop1 data", int'(dq[0]), 'h5C);
        pulse_deq(0, 3);
        check("t2 pop2 len", dut_len(0), 0);
        check("t2 pop2 data", int'(dq[0]), 0);
        pulse_deq(0, 3);
        check("t2 pop3 len", dut_len(0), 0);
        check("t2 pop3 empty", int'(em[0]), 1);

        // 3: stall policy
        for (int k = 0; k < 8; k++) send_word(0, 8'h10 + 8'(k));
        send_word(0, 8'hE9);
        repeat (3) @(negedge clk);
        check("t3 stall status", int'(st[0]), 0);
        check("t3 stall len", dut_len(0), 8);
        check("t3 stall full", int'(fl[0]), 1);
        pulse_deq(0, 1);
        check("t3 pop+push len", dut_len(0), 8);
        check("t3 pop+push head", int'(dq[0]), 'h11);
        check("t3 idle again", int'(st[0]), 1);
        for (int k = 2; k < 8; k++) begin
            pulse_deq(0, 1);
            check("t3 drain order", int'(dq[0]), 'h10 + k);
        end
        pulse_deq(0, 1);
        check("t3 ninth word", int'(dq[0]), 'hE9);
        pulse_deq(0, 1);
        check("t3 drained", dut_len(0), 0);

        // 4: drop policy
        for (int k = 0; k < 8; k++) send_word(1, 8'h20 + 8'(k));
        send_word(1, 8'hFF);
        check("t4 overflow pulse", int'(ovf[1]), 1);
        check("t4 len", dut_len(1), 8);
        check("t4 head", int'(dq[1]), 'h20);
        @(negedge clk);
        check("t4 overflow one cycle", int'(ovf[1]), 0);
        check("t4 status", int'(st[1]), 1);

        // 5: framing error
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr[0] = 1'b1; din[0] = 1'b1;
        end
        @(negedge clk);
        wr[0] = 1'b0; din[0] = 1'b0;
        @(negedge clk);
        check("t5 frame_error", int'(fe[0]), 1);
        check("t5 len", dut_len(0), 0);
        @(negedge clk);
        check("t5 frame_error one cycle", int'(fe[0]), 0);
        send_word(0, 8'h3C);
        check("t5 recovery data", int'(dq[0]), 'h3C);
        check("t5 recovery len", dut_len(0), 1);

        // 6: MSB-first, depth 5, wrapping pointers
        for (int j = 0; j < 12; j++) begin
            send_word(2, 8'(j * 37 + 5));
            if (j >= 2) pulse_deq(2, 1);
        end
        send_word(2, 8'hC7);
        check("t6 len", dut_len(2), 3);
        check("t6 head", int'(dq[2]), (10 * 37 + 5) & 'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr[2] = 1'b1; din[2] = 1'b1;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(2);
        check_reset_vals(0);
        check_reset_vals(1);
        wr[2] = 1'b0; din[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6 after reset len", dut_len(2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
